hazard_stall_ctrl: RTL and testbench

- Pipeline hazard and sequencing controller for the 5-stage MIPS core.
- Drives write-enables and flushes for PC, IF/ID and ID/EX, plus the EX/MEM bubble.
- Handles three events: load-use stalls, control-transfer flushes resolved in EX, and multi-cycle mult/div freezes.
- Keeps saturating stall and flush performance counters.

---
 rtl/hazard_stall_ctrl.sv | 163 ++++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
// Hazard and sequencing controller for the 5-stage MIPS pipeline.
// Resolves three events each cycle and drives the pipeline-register enables:
//   - control transfer resolved in EX  -> flush IF/ID and ID/EX
//   - multi-cycle mult/div in EX       -> freeze PC, IF/ID, ID/EX; bubble EX/MEM
//   - load-use dependency              -> hold PC and IF/ID, bubble ID/EX
// Also keeps two saturating performance counters (stall cycles, flushes).
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   id_rs, id_rt            source register fields of the instruction in ID
//   id_uses_rs, id_uses_rt  ID instruction actually reads rs / rt
//   ex_MemRead, ex_rt       EX instruction is a load, and its destination
//   ex_redirect             taken branch / jump resolved in EX
//   ex_muldiv_start         EX holds a mult/div (high while it stays in EX)
//   pc_write, if_id_write, id_ex_write   load enables
//   if_id_flush, id_ex_flush, ex_mem_bubble   clears / bubble insertion
//   md_done                 pulse on the mult/div's final EX cycle
//   stall_count             cycles with pc_write low (saturating)
//   flush_count             honoured redirects (saturating)
// -----------------------------------------------------------------------------
module hazard_stall_ctrl #(
    parameter int unsigned MULDIV_LAT = 8,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             ex_MemRead,
    input  logic [4:0]       ex_rt,
    input  logic             ex_redirect,
    input  logic             ex_muldiv_start,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_flush,
    output logic             ex_mem_bubble,
    output logic             md_done,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_MD_BUSY = 1'b1
    } state_e;

    // The start cycle is already a freeze cycle, so the busy countdown covers
    // the remaining MULDIV_LAT-2 freeze cycles and ends on the done cycle.
    localparam logic [4:0]       MD_INIT  = 5'(MULDIV_LAT - 2);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;
    logic             load_use_s;
    logic             flush_hit_s;

    // Load-use: the loaded register (never $zero) is read by the ID instruction.
    assign load_use_s = ex_MemRead && (ex_rt != 5'd0) &&
                        ((id_uses_rs && (id_rs == ex_rt)) ||
                         (id_uses_rt && (id_rt == ex_rt)));

    // Control outputs and FSM next state; reset forces defaults.
    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_write   = 1'b1;
        id_ex_flush   = 1'b0;
        ex_mem_bubble = 1'b0;
        md_done       = 1'b0;
        flush_hit_s   = 1'b0;
        state_d       = state_q;
        cnt_d         = cnt_q;
        if (reset) begin
            state_d = ST_RUN;
            cnt_d   = 5'd0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (ex_redirect) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        flush_hit_s = 1'b1;
                    end else if (ex_muldiv_start) begin
                        pc_write      = 1'b0;
                        if_id_write   = 1'b0;
                        id_ex_write   = 1'b0;
                        ex_mem_bubble = 1'b1;
                        state_d       = ST_MD_BUSY;
                        cnt_d         = MD_INIT;
                    end else if (load_use_s) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_flush = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_MD_BUSY: begin
                    // All other events are ignored while the unit owns EX.
                    if (cnt_q != 5'd0) begin
                        pc_write      = 1'b0;
                        if_id_write   = 1'b0;
                        id_ex_write   = 1'b0;
                        ex_mem_bubble = 1'b1;
                        cnt_d         = cnt_q - 5'd1;
                    end else begin
                        md_done = 1'b1;
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = 5'd0;
                end
            endcase
        end
    end

    // Saturating performance counter next values.
    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (!reset && !pc_write && (stall_count_q != CNT_MAX)) begin
            stall_count_d = stall_count_q + CNT_ONE;
        end else begin
            stall_count_d = stall_count_q;
        end
        if (flush_hit_s && (flush_count_q != CNT_MAX)) begin
            flush_count_d = flush_count_q + CNT_ONE;
        end else begin
            flush_count_d = flush_count_q;
        end
    end

    // State, countdown and counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_RUN;
            cnt_q         <= 5'd0;
            stall_count_q <= {CNT_W{1'b0}};
            flush_count_q <= {CNT_W{1'b0}};
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_stall_ctrl
// Self-checking bench for hazard_stall_ctrl. The main instance (MULDIV_LAT=8,
// CNT_W=32) is driven cycle by cycle; an independent behavioural model pushes
// the expected outputs to a scoreboard queue, which is popped and compared once
// the outputs have settled. A second instance (MULDIV_LAT=2, CNT_W=4) exercises
// counter saturation and the shortest mult/div latency.
// -----------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

    localparam int LAT = 8;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Main instance signals
    logic        reset, id_uses_rs, id_uses_rt, ex_MemRead, ex_redirect, ex_muldiv_start;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_bubble, md_done;
    logic [31:0] stall_count, flush_count;

    // Small instance signals
    logic        s_reset, s_id_uses_rs, s_id_uses_rt, s_ex_MemRead, s_ex_redirect, s_ex_muldiv_start;
    logic [4:0]  s_id_rs, s_id_rt, s_ex_rt;
    logic        s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_write, s_id_ex_flush, s_ex_mem_bubble, s_md_done;
    logic [3:0]  s_stall_count, s_flush_count;

    hazard_stall_ctrl #(.MULDIV_LAT(LAT), .CNT_W(32)) dut (
        .clock(clock), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_MemRead(ex_MemRead), .ex_rt(ex_rt), .ex_redirect(ex_redirect),
        .ex_muldiv_start(ex_muldiv_start),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush), .ex_mem_bubble(ex_mem_bubble),
        .md_done(md_done), .stall_count(stall_count), .flush_count(flush_count)
    );

    hazard_stall_ctrl #(.MULDIV_LAT(2), .CNT_W(4)) dut_small (
        .clock(clock), .reset(s_reset),
        .id_rs(s_id_rs), .id_rt(s_id_rt), .id_uses_rs(s_id_uses_rs), .id_uses_rt(s_id_uses_rt),
        .ex_MemRead(s_ex_MemRead), .ex_rt(s_ex_rt), .ex_redirect(s_ex_redirect),
        .ex_muldiv_start(s_ex_muldiv_start),
        .pc_write(s_pc_write), .if_id_write(s_if_id_write), .if_id_flush(s_if_id_flush),
        .id_ex_write(s_id_ex_write), .id_ex_flush(s_id_ex_flush), .ex_mem_bubble(s_ex_mem_bubble),
        .md_done(s_md_done), .stall_count(s_stall_count), .flush_count(s_flush_count)
    );

    typedef struct packed {
        logic        pc_write;
        logic        if_id_write;
        logic        if_id_flush;
        logic        id_ex_write;
        logic        id_ex_flush;
        logic        ex_mem_bubble;
        logic        md_done;
        logic [31:0] stall_count;
        logic [31:0] flush_count;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int step_no  = 0;

    // Reference model state: busy flag, cycles the mult/div has spent in EX,
    // and the expected counter values.
    bit          m_busy = 1'b0;
    int          m_occ  = 0;
    logic [31:0] m_stall = 32'd0;
    logic [31:0] m_flush = 32'd0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @step %0d: got %0h expected %0h", tag, step_no, obs, exp);
        end
    endtask

    // Drive one cycle on the main instance, predict, then compare.
    task automatic drive(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic mr,
                         input logic [4:0] ert, input logic redir, input logic md);
        exp_t e;
        exp_t o;
        logic lu;
        logic freeze;
        logic stall;
        logic flush_ev;
        @(negedge clock);
        step_no++;
        reset = rst; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
        ex_MemRead = mr; ex_rt = ert; ex_redirect = redir; ex_muldiv_start = md;

        lu = mr && (ert != 5'd0) && ((urs && (rs == ert)) || (urt && (rt == ert)));
        e = '0;
        e.pc_write    = 1'b1;
        e.if_id_write = 1'b1;
        e.id_ex_write = 1'b1;
        e.stall_count = m_stall;
        e.flush_count = m_flush;
        freeze = 1'b0; stall = 1'b0; flush_ev = 1'b0;
        if (rst) begin
            m_busy = 1'b0;
        end else if (m_busy) begin
            m_occ++;
            if (m_occ < LAT) begin
                freeze = 1'b1;
            end else begin
                e.md_done = 1'b1;
                m_busy = 1'b0;
            end
        end else if (redir) begin
            flush_ev = 1'b1;
        end else if (md) begin
            freeze = 1'b1;
            m_busy = 1'b1;
            m_occ  = 1;
        end else if (lu) begin
            stall = 1'b1;
        end
        if (freeze) begin
            e.pc_write = 1'b0; e.if_id_write = 1'b0; e.id_ex_write = 1'b0; e.ex_mem_bubble = 1'b1;
        end
        if (stall) begin
            e.pc_write = 1'b0; e.if_id_write = 1'b0; e.id_ex_flush = 1'b1;
        end
        if (flush_ev) begin
            e.if_id_flush = 1'b1; e.id_ex_flush = 1'b1;
        end
        sb_q.push_back(e);

        // Counter values seen after the coming edge
        if (rst) begin
            m_stall = 32'd0;
            m_flush = 32'd0;
        end else begin
            if (!e.pc_write && (m_stall != 32'hFFFF_FFFF)) m_stall = m_stall + 32'd1;
            if (flush_ev && (m_flush != 32'hFFFF_FFFF)) m_flush = m_flush + 32'd1;
        end

        #1;
        o = sb_q.pop_front();
        check_value("pc_write",      {31'd0, pc_write},      {31'd0, o.pc_write});
        check_value("if_id_write",   {31'd0, if_id_write},   {31'd0, o.if_id_write});
        check_value("if_id_flush",   {31'd0, if_id_flush},   {31'd0, o.if_id_flush});
        check_value("id_ex_write",   {31'd0, id_ex_write},   {31'd0, o.id_ex_write});
        check_value("id_ex_flush",   {31'd0, id_ex_flush},   {31'd0, o.id_ex_flush});
        check_value("ex_mem_bubble", {31'd0, ex_mem_bubble}, {31'd0, o.ex_mem_bubble});
        check_value("md_done",       {31'd0, md_done},       {31'd0, o.md_done});
        check_value("stall_count",   stall_count,            o.stall_count);
        check_value("flush_count",   flush_count,            o.flush_count);
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        ex_MemRead = 1'b0; ex_rt = 5'd0; ex_redirect = 1'b0; ex_muldiv_start = 1'b0;
        s_reset = 1'b1; s_id_rs = 5'd0; s_id_rt = 5'd0; s_id_uses_rs = 1'b0; s_id_uses_rt = 1'b0;
        s_ex_MemRead = 1'b0; s_ex_rt = 5'd0; s_ex_redirect = 1'b0; s_ex_muldiv_start = 1'b0;
        @(posedge clock);

        // Reset state
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        // Load-use on rs, then non-hazards
        drive(1'b0, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0);
        idle();
        drive(1'b0, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
        drive(1'b0, 5'd3, 5'd0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0);
        drive(1'b0, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0);
        // Load-use on rt, and rt not read
        drive(1'b0, 5'd0, 5'd7, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0);
        drive(1'b0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);
        idle();

        // Mult/div held for its full occupancy, with a load-use pending
        for (int i = 0; i < LAT; i++) drive(1'b0, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0, 1'b1);
        idle();
        idle();

        // Redirect wins over load-use and mult/div
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        drive(1'b0, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0);
        idle();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
        // Redirect during the freeze is ignored
        for (int i = 0; i < LAT; i++) drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, (i == 3), 1'b1);
        idle();

        // Reset on the third busy cycle aborts the freeze
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        idle();
        idle();

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 59) == 0),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
        end

        // Small instance: saturation and two-cycle mult/div
        @(negedge clock);
        s_reset = 1'b1;
        @(negedge clock);
        s_reset = 1'b0;
        #1;
        check_value("s_stall_reset", {28'd0, s_stall_count}, 32'd0);
        check_value("s_flush_reset", {28'd0, s_flush_count}, 32'd0);
        s_ex_MemRead = 1'b1; s_ex_rt = 5'd5; s_id_rs = 5'd5; s_id_uses_rs = 1'b1;
        repeat (20) @(negedge clock);
        #1;
        check_value("s_lu_pc_write", {31'd0, s_pc_write}, 32'd0);
        check_value("s_stall_sat", {28'd0, s_stall_count}, 32'd15);
        s_ex_MemRead = 1'b0;
        s_ex_redirect = 1'b1;
        repeat (18) @(negedge clock);
        #1;
        check_value("s_flush_sat", {28'd0, s_flush_count}, 32'd15);
        check_value("s_stall_hold", {28'd0, s_stall_count}, 32'd15);
        s_ex_redirect = 1'b0;
        s_ex_muldiv_start = 1'b1;
        #1;
        check_value("s_md_freeze", {30'd0, s_pc_write, s_ex_mem_bubble}, 32'd1);
        check_value("s_md_nodone", {31'd0, s_md_done}, 32'd0);
        @(negedge clock);
        #1;
        check_value("s_md_done", {31'd0, s_md_done}, 32'd1);
        check_value("s_md_release", {30'd0, s_pc_write, s_ex_mem_bubble}, 32'd2);
        check_value("s_stall_sat2", {28'd0, s_stall_count}, 32'd15);
        s_ex_muldiv_start = 1'b0;
        @(negedge clock);
        #1;
        check_value("s_md_pulse", {31'd0, s_md_done}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
